// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_mp_pkg
// Shared definitions for the multi-port register file:
//   - default DATA_WIDTH / ADDR_WIDTH
//   - INIT/RUN state encoding
//   - index of the hard-wired zero register (x0)
// Optional feature macro used by the design: REGFILE_BYPASS_EN
// -----------------------------------------------------------------------------
package regfile_mp_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int ZERO_REG       = 0;

    // INIT: post-reset zeroing sweep; RUN: normal operation
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bus between decode/issue + write-back (master) and the register file (slave).
//   raddr     NUM_READ packed read addresses (port i at [i*ADDR_WIDTH +: ADDR_WIDTH])
//   rdata     NUM_READ packed read data
//   rbusy     scoreboard busy bit per read port
//   we0/1, waddr0/1, wdata0/1   two write-back lanes (lane 1 wins on collision)
//   rsv_en, rsv_addr            mark a destination register as pending
//   ready     status level, high once the zeroing sweep is done
//
// Handshake: there is no valid/ready transfer protocol on this bus. Reads are
// combinational and always valid; writes/reserves are accepted on every rising
// edge while ready is high and silently ignored while ready is low.
// -----------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int DATA_WIDTH = regfile_mp_pkg::DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = regfile_mp_pkg::ADDR_WIDTH_DEF,
    parameter int NUM_READ   = 2
) ();

    logic [NUM_READ*ADDR_WIDTH-1:0] raddr;
    logic [NUM_READ*DATA_WIDTH-1:0] rdata;
    logic [NUM_READ-1:0]            rbusy;
    logic                           we0;
    logic                           we1;
    logic [ADDR_WIDTH-1:0]          waddr0;
    logic [ADDR_WIDTH-1:0]          waddr1;
    logic [DATA_WIDTH-1:0]          wdata0;
    logic [DATA_WIDTH-1:0]          wdata1;
    logic                           rsv_en;
    logic [ADDR_WIDTH-1:0]          rsv_addr;
    logic                           ready;

    modport master (
        output raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, rsv_en, rsv_addr,
        input  rdata, rbusy, ready
    );

    modport slave (
        input  raddr, we0, we1, waddr0, waddr1, wdata0, wdata1, rsv_en, rsv_addr,
        output rdata, rbusy, ready
    );

endinterface

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One combinational read port: x0 masking, busy lookup and (optionally) the
// write-through bypass from the two write-back lanes.
//   run        high in RUN; outputs are forced to 0 otherwise
//   raddr      register index for this port
//   arr_word   array contents at raddr (looked up by the parent)
//   busy_vec   registered scoreboard bits
//   we*/waddr*/wdata*  write-back lanes, used only for the bypass
//   rdata, rbusy       port outputs
// Macro REGFILE_BYPASS_EN: when defined, a read hitting an active write lane
// returns that lane's data (lane 1 over lane 0) and reports not-busy.
// -----------------------------------------------------------------------------
module regfile_read_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  run,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] arr_word,
    input  logic [DEPTH-1:0]      busy_vec,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rbusy
);

    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (run && (raddr != ADDR_WIDTH'(ZERO_REG))) begin
            rdata = arr_word;
            rbusy = busy_vec[raddr];
`ifdef REGFILE_BYPASS_EN
            // The same-cycle write-back resolves the hazard, so busy drops too.
            if (we1 && (waddr1 == raddr)) begin
                rdata = wdata1;
                rbusy = 1'b0;
            end else if (we0 && (waddr0 == raddr)) begin
                rdata = wdata0;
                rbusy = 1'b0;
            end
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    // Lane inputs only feed the bypass; sink them when it is compiled out.
    logic unused_lanes;
    assign unused_lanes = ^{we0, waddr0, wdata0, we1, waddr1, wdata1};
`endif

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port integer register file for the RV32I core: NUM_READ combinational
// read ports, two prioritised write-back lanes, per-register busy scoreboard,
// and a post-reset sweep that zeroes the array one entry per cycle.
//   clk        core clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        regfile_mp_if slave modport (reads, writes, reserve, ready)
//   dbg_state  current INIT/RUN state
// Macro REGFILE_BYPASS_EN (see regfile_read_port): enables write-through reads.
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_READ   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_mp_if.slave   bus,
    output rf_state_e     dbg_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    rf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic run;
    logic wr0_en;
    logic wr1_en;

    assign run    = (state_q == ST_RUN);
    assign wr0_en = run && bus.we0 && (bus.waddr0 != ADDR_WIDTH'(ZERO_REG));
    assign wr1_en = run && bus.we1 && (bus.waddr1 != ADDR_WIDTH'(ZERO_REG));

    // Next-state / scoreboard logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int a = 0; a < DEPTH; a++) begin
                    // A reserve is the newer producer, so it beats a clear.
                    if (bus.rsv_en && (bus.rsv_addr == ADDR_WIDTH'(a))) begin
                        busy_d[a] = 1'b1;
                    end else if ((bus.we0 && (bus.waddr0 == ADDR_WIDTH'(a))) ||
                                 (bus.we1 && (bus.waddr1 == ADDR_WIDTH'(a)))) begin
                        busy_d[a] = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
        busy_d[ZERO_REG] = 1'b0;
        // Registered alongside state so ready rises on the edge that ends the sweep.
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Array storage is not reset; the INIT sweep zeroes it. Lane 1 is written
    // last so it wins when both lanes target the same register.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem_q[cnt_q] <= '0;
        end
        if (wr0_en) begin
            mem_q[bus.waddr0] <= bus.wdata0;
        end
        if (wr1_en) begin
            mem_q[bus.waddr1] <= bus.wdata1;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] port_addr;
        logic [DATA_WIDTH-1:0] port_word;
        logic [DATA_WIDTH-1:0] port_data;
        logic                  port_busy;

        assign port_addr = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign port_word = mem_q[port_addr];

        regfile_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (DEPTH)
        ) u_rd (
            .run      (run),
            .raddr    (port_addr),
            .arr_word (port_word),
            .busy_vec (busy_q),
            .we0      (bus.we0),
            .waddr0   (bus.waddr0),
            .wdata0   (bus.wdata0),
            .we1      (bus.we1),
            .waddr1   (bus.waddr1),
            .wdata1   (bus.wdata1),
            .rdata    (port_data),
            .rbusy    (port_busy)
        );

        assign bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] = port_data;
        assign bus.rbusy[i]                          = port_busy;
    end

    assign bus.ready = ready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Randomised + directed bench for regfile_mp with a behavioural model and an
// expected-response queue checked by an independent monitor at each negedge.
// -----------------------------------------------------------------------------
module tb_regfile_mp;
    import regfile_mp_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_state_e dbg_state;

    regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) rf_if ();

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (rf_if.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0]   tag;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        logic [1:0]    bsy;
        logic          rdy;
    } exp_t;

    exp_t exp_q[$];
    int   tests   = 0;
    int   fails   = 0;
    int   cur_tag = 0;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_ready;
    int            m_init_left;

    function automatic void model_reset();
        m_ready     = 1'b0;
        m_init_left = DEPTH;
        for (int a = 0; a < DEPTH; a++) m_busy[a] = 1'b0;
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] ra, output logic bsy);
        logic [DW-1:0] d;
        d   = '0;
        bsy = 1'b0;
        if (m_ready && ra != 0) begin
            d   = m_mem[ra];
            bsy = m_busy[ra];
`ifdef REGFILE_BYPASS_EN
            if (rf_if.we1 && rf_if.waddr1 == ra) begin
                d   = rf_if.wdata1;
                bsy = 1'b0;
            end else if (rf_if.we0 && rf_if.waddr0 == ra) begin
                d   = rf_if.wdata0;
                bsy = 1'b0;
            end
`endif
        end
        return d;
    endfunction

    // Effect of one rising edge with rst_n high.
    function automatic void model_edge();
        if (!m_ready) begin
            m_init_left--;
            if (m_init_left == 0) begin
                m_ready = 1'b1;
                for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
            end
        end else begin
            if (rf_if.we0 && rf_if.waddr0 != 0) m_mem[rf_if.waddr0] = rf_if.wdata0;
            if (rf_if.we1 && rf_if.waddr1 != 0) m_mem[rf_if.waddr1] = rf_if.wdata1;
            if (rf_if.we0) m_busy[rf_if.waddr0] = 1'b0;
            if (rf_if.we1) m_busy[rf_if.waddr1] = 1'b0;
            if (rf_if.rsv_en && rf_if.rsv_addr != 0) m_busy[rf_if.rsv_addr] = 1'b1;
        end
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge: records what the outputs must be during
    // this cycle, then advances the model across the next edge.
    task automatic cycle();
        exp_t e;
        logic b0, b1;
        if (!rst_n) model_reset();
        cur_tag++;
        e.tag = cur_tag;
        e.rd0 = exp_read(rf_if.raddr[0 +: AW], b0);
        e.rd1 = exp_read(rf_if.raddr[AW +: AW], b1);
        e.bsy = {b1, b0};
        e.rdy = m_ready;
        exp_q.push_back(e);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic idle();
        rf_if.we0    = 1'b0;
        rf_if.we1    = 1'b0;
        rf_if.rsv_en = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rf_if.raddr[0 +: AW]  = AW'(a0);
        rf_if.raddr[AW +: AW] = AW'(a1);
    endtask

    task automatic wr0(input int a, input logic [DW-1:0] d);
        rf_if.we0 = 1'b1; rf_if.waddr0 = AW'(a); rf_if.wdata0 = d;
    endtask

    task automatic wr1(input int a, input logic [DW-1:0] d);
        rf_if.we1 = 1'b1; rf_if.waddr1 = AW'(a); rf_if.wdata1 = d;
    endtask

    task automatic rsv(input int a);
        rf_if.rsv_en = 1'b1; rf_if.rsv_addr = AW'(a);
    endtask

    task automatic rand_cycle(input int amax);
        set_rd($urandom_range(0, amax), $urandom_range(0, amax));
        rf_if.we0      = ($urandom_range(0, 2) == 0);
        rf_if.waddr0   = AW'($urandom_range(0, amax));
        rf_if.wdata0   = $urandom;
        rf_if.we1      = ($urandom_range(0, 2) == 0);
        rf_if.waddr1   = AW'($urandom_range(0, amax));
        rf_if.wdata1   = $urandom;
        rf_if.rsv_en   = ($urandom_range(0, 2) == 0);
        rf_if.rsv_addr = AW'($urandom_range(0, amax));
        cycle();
    endtask

    // ---------------- monitor ----------------
    task automatic check(input string name, input int tag, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].tag == cur_tag) begin
            e = exp_q.pop_front();
            check("rdata0", cur_tag, rf_if.rdata[0 +: DW], e.rd0);
            check("rdata1", cur_tag, rf_if.rdata[DW +: DW], e.rd1);
            check("rbusy",  cur_tag, DW'(rf_if.rbusy), DW'(e.bsy));
            check("ready",  cur_tag, DW'(rf_if.ready), DW'(e.rdy));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        idle();
        set_rd(0, 0);
        rf_if.waddr0 = '0; rf_if.wdata0 = '0;
        rf_if.waddr1 = '0; rf_if.wdata1 = '0;
        rf_if.rsv_addr = '0;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        model_reset();

        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (3) cycle();

        // Reset release: sweep of 32 cycles, writes/reserves ignored meanwhile
        rst_n = 1'b1;
        wr0(5, 32'hDEADBEEF);
        rsv(5);
        set_rd(5, 5);
        repeat (32) cycle();
        idle();
        repeat (2) cycle();

        // Basic write and x0 discard
        wr0(3, 32'h12345678); set_rd(3, 3); cycle();
        idle(); cycle();
        wr0(0, 32'hFFFFFFFF); set_rd(0, 3); cycle();
        idle(); cycle();

        // Dual-write collision: lane 1 wins
        wr0(7, 32'hAAAA0000); wr1(7, 32'h0000BBBB); set_rd(7, 3); cycle();
        idle(); cycle();

        // Scoreboard set / clear / set-beats-clear
        rsv(9); set_rd(9, 7); cycle();
        idle(); cycle();
        wr1(9, 32'h99999999); cycle();
        idle(); cycle();
        rsv(9); wr0(9, 32'h11119999); cycle();
        idle(); cycle();
        rsv(0); cycle();
        idle(); set_rd(0, 9); cycle();

        // Write-through visibility on the write cycle vs. next cycle
        wr0(4, 32'hCAFEF00D); set_rd(4, 4); cycle();
        idle(); cycle();
        wr1(4, 32'h0BADF00D); wr0(4, 32'h55555555); rsv(4); cycle();
        idle(); cycle();

        // Randomised traffic: narrow address range for collisions, then full
        repeat (300) rand_cycle(7);
        repeat (200) rand_cycle(DEPTH - 1);

        // Mid-sweep reset restarts the sweep from 0
        idle();
        rst_n = 1'b0; cycle();
        rst_n = 1'b1;
        repeat (10) cycle();
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (33) cycle();
        repeat (100) rand_cycle(DEPTH - 1);
        idle(); set_rd(1, 2); cycle();

        @(negedge clk); #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
